// File: rtl/divider_pkg.sv
// Shared types for the iterative signed divider: FSM state encoding and
// the width of the per-bit iteration counter.
package divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // One bit minimum so a 2-bit divider still has a usable counter.
    function automatic int cnt_bits(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/divider_adder.sv
// Plain two's complement adder used for the divider's trial subtraction
// (partial remainder plus negated divisor magnitude).
module divider_adder #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/divider.sv
// Iterative restoring signed divider: one quotient bit per clock, fixed
// latency of width+1 edges from accepted start to the valid pulse.
module divider
    import divider_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             divide_by_zero
);

    localparam int CW = cnt_bits(width);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [width:0]   r_rem;
    logic [width:0]   r_neg_div;
    logic [width-1:0] r_dq;
    logic             r_sign_a;
    logic             r_sign_d;
    logic             r_zero;
    logic             r_valid;
    logic [width-1:0] r_quot;
    logic [width-1:0] r_remd;
    logic             r_dbz;

    logic [width:0]   w_div_ext;
    logic [width:0]   w_neg_div;
    logic [width-1:0] w_dividend_mag;
    logic [width:0]   w_shift;
    logic [width:0]   w_trial;
    logic             w_qbit;

    // Magnitudes are unsigned, so the most-negative operand needs no extra bit
    // here; the divisor path is sign-extended to width+1 before negation.
    assign w_div_ext      = {divisor[width-1], divisor};
    assign w_neg_div      = divisor[width-1] ? w_div_ext : -w_div_ext;
    assign w_dividend_mag = dividend[width-1] ? -dividend : dividend;

    // r_dq shifts dividend bits out of its MSB and quotient bits into its LSB.
    assign w_shift = {r_rem[width-1:0], r_dq[width-1]};
    assign w_qbit  = ~w_trial[width];

    divider_adder #(.WIDTH(width + 1)) u_adder (
        .i_a   (w_shift),
        .i_b   (r_neg_div),
        .o_sum (w_trial)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_neg_div <= '0;
            r_dq      <= '0;
            r_sign_a  <= 1'b0;
            r_sign_d  <= 1'b0;
            r_zero    <= 1'b0;
            r_valid   <= 1'b0;
            r_quot    <= '0;
            r_remd    <= '0;
            r_dbz     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dq      <= w_dividend_mag;
                        r_neg_div <= w_neg_div;
                        r_sign_a  <= dividend[width-1];
                        r_sign_d  <= divisor[width-1];
                        r_zero    <= (divisor == '0);
                        r_rem     <= '0;
                        r_cnt     <= CW'(width - 1);
                    end
                end
                S_CALC: begin
                    r_dq  <= {r_dq[width-2:0], w_qbit};
                    r_rem <= w_qbit ? w_trial : w_shift;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    // A zero divisor leaves |dividend| in r_rem, so the sign
                    // fix-up below also yields remainder = dividend.
                    if (r_zero) begin
                        r_quot <= '1;
                    end else begin
                        r_quot <= (r_sign_a ^ r_sign_d) ? -r_dq : r_dq;
                    end
                    r_remd  <= r_sign_a ? -r_rem[width-1:0] : r_rem[width-1:0];
                    r_dbz   <= r_zero;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready          = (r_state == S_IDLE);
    assign valid          = r_valid;
    assign quotient       = r_quot;
    assign remainder      = r_remd;
    assign divide_by_zero = r_dbz;

endmodule
